// File: rtl/ntt_mod_mul.sv
// Pipelined Barrett modular multiplier: out_data = (in_a * in_b) mod in_q, four
// register stages, with a sideband tag and valid/ready flow control.
module ntt_mod_mul #(
  parameter int K     = 62,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [63:0]      in_q,
  input  logic [63:0]      in_mu,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int TW = K + 1;
  localparam int RW = K + 2;

  // Barrett leaves r in [0, 3q); fold it back into [0, q).
  function automatic logic [63:0] reduce_3q(input logic [RW-1:0] r, input logic [63:0] q);
    logic [64:0] r_x;
    logic [64:0] q1_x;
    logic [64:0] q2_x;
    r_x  = 65'(r);
    q1_x = {1'b0, q};
    q2_x = {q, 1'b0};
    if (r_x >= q2_x)      return 64'(r_x - q2_x);
    else if (r_x >= q1_x) return 64'(r_x - q1_x);
    else                  return 64'(r_x);
  endfunction

  logic en;
  logic vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;

  // A held output freezes every stage together; bubbles stay in place.
  assign en       = !(vld_p4_q && !out_ready);
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
    end else if (en) begin
      vld_p1_q <= in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      vld_p4_q <= vld_p3_q;
    end
  end

  // ---- stage 1: full 128-bit product ----
  logic [127:0]     x_d;
  logic [127:0]     x_p1_q;
  logic [63:0]      q_p1_q;
  logic [63:0]      mu_p1_q;
  logic [TAG_W-1:0] tag_p1_q;

  always_comb begin
    x_d = {64'd0, in_a} * {64'd0, in_b};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      x_p1_q   <= x_d;
      q_p1_q   <= in_q;
      mu_p1_q  <= in_mu;
      tag_p1_q <= in_tag;
    end
  end

  // ---- stage 2: quotient estimate t ----
  logic [191:0]     prod_d;
  logic [TW-1:0]    t_d;
  logic [RW-1:0]    xlo_d;
  logic [TW-1:0]    t_p2_q;
  logic [RW-1:0]    xlo_p2_q;
  logic [63:0]      q_p2_q;
  logic [TAG_W-1:0] tag_p2_q;

  always_comb begin
    prod_d = {64'd0, x_p1_q >> (K - 1)} * {128'd0, mu_p1_q};
    t_d    = TW'(prod_d >> (K + 1));
    xlo_d  = RW'(x_p1_q);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      t_p2_q   <= t_d;
      xlo_p2_q <= xlo_d;
      q_p2_q   <= q_p1_q;
      tag_p2_q <= tag_p1_q;
    end
  end

  // ---- stage 3: remainder candidate modulo 2^(K+2) ----
  logic [RW-1:0]    tq_d;
  logic [RW-1:0]    r_d;
  logic [RW-1:0]    r_p3_q;
  logic [63:0]      q_p3_q;
  logic [TAG_W-1:0] tag_p3_q;

  always_comb begin
    tq_d = RW'(t_p2_q * q_p2_q);
    r_d  = xlo_p2_q - tq_d;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      r_p3_q   <= r_d;
      q_p3_q   <= q_p2_q;
      tag_p3_q <= tag_p2_q;
    end
  end

  // ---- stage 4: final correction into [0, q) ----
  logic [63:0]      res_d;
  logic [63:0]      res_p4_q;
  logic [TAG_W-1:0] tag_p4_q;

  always_comb begin
    res_d = reduce_3q(r_p3_q, q_p3_q);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      res_p4_q <= res_d;
      tag_p4_q <= tag_p3_q;
    end
  end

  // Datapath registers carry no reset, so idle outputs are forced to zero.
  assign out_valid = vld_p4_q;
  assign out_data  = vld_p4_q ? res_p4_q : 64'd0;
  assign out_tag   = vld_p4_q ? tag_p4_q : '0;

endmodule

// File: tb/tb_ntt_mod_mul.sv
// Directed bench for ntt_mod_mul: hand-computed vectors plus a 128-bit
// reference scoreboard for streaming, stall, modulus-switch and reset cases.
module tb_ntt_mod_mul;

  localparam logic [63:0] Q0  = 64'h3FFF_FFFF_FFFF_FFFF;  // 2^62-1
  localparam logic [63:0] MU0 = 64'h4000_0000_0000_0001;  // 2^62+1
  localparam logic [63:0] Q1  = 64'h3FFF_FFFF_FFFF_FFC7;  // 2^62-57
  localparam logic [63:0] Q2  = 64'h2000_0000_0000_0001;  // 2^61+1

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a, in_b, in_q, in_mu;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_tag;

  ntt_mod_mul #(.K(62), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_q(in_q), .in_mu(in_mu), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  tag;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0, n_fail = 0;
  int          cyc = 0, n_out = 0, n_stall = 0, n_notready = 0;
  bit          chk_lat = 1'b0;
  bit          xfer_in;
  bit          was_stall = 1'b0;
  logic [63:0] hold_data;
  logic [7:0]  hold_tag;
  logic [63:0] cur_exp;
  logic [63:0] mu1, mu2;

  function automatic logic [63:0] mod_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] q);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p % {64'd0, q});
  endfunction

  function automatic logic [63:0] mu_of(input logic [63:0] q);
    logic [127:0] n;
    n = 128'd1 << 124;
    return 64'(n / {64'd0, q});
  endfunction

  function automatic logic [63:0] rnd_below(input logic [63:0] q);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r % q;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // One clock: sample handshakes mid-cycle, score outputs, record accepted inputs.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    xfer_in = in_valid && in_ready && !rst;
    chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (!in_ready) n_notready++;
    if (was_stall) begin
      chk("hold_data", out_data, hold_data);
      chk("hold_tag", 64'(out_tag), 64'(hold_tag));
    end
    was_stall = out_valid && !out_ready;
    if (was_stall) begin
      hold_data = out_data;
      hold_tag  = out_tag;
      n_stall++;
    end
    if (out_valid && out_ready) begin
      n_out++;
      chk("pending", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data", out_data, e.data);
        chk("tag", 64'(out_tag), 64'(e.tag));
        if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd4);
      end
    end
    if (xfer_in) sb.push_back('{data: cur_exp, tag: in_tag, cyc: cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q,
                       input logic [63:0] mu, input logic [7:0] tag, input logic [63:0] expv);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_q     = q;
    in_mu    = mu;
    in_tag   = tag;
    cur_exp  = expv;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) idle();
    chk("drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    logic [63:0] sa[8];
    logic [63:0] sbv[8];
    int          n0, k;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_q = Q0; in_mu = MU0; in_tag = '0; cur_exp = '0;
    hold_data = '0; hold_tag = '0;
    mu1 = mu_of(Q1);
    mu2 = mu_of(Q2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset; out_ready low must not matter while nothing is valid.
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    chk_lat   = 1'b1;
    drive(64'd2, 64'd3, Q0, MU0, 8'h11, 64'd6);
    drain(10);
    drive(Q0 - 64'd1, Q0 - 64'd1, Q0, MU0, 8'h12, 64'd1);
    drive(64'd0, Q0 - 64'd1, Q0, MU0, 8'h13, 64'd0);
    drive(64'h2000_0000_0000_0000, 64'd4, Q0, MU0, 8'h14, 64'd2);
    drive(Q0 - 64'd1, 64'd0, Q0, MU0, 8'h15, 64'd0);
    drain(10);
    chk("directed_count", 64'(n_out), 64'd5);

    // Back-to-back random stream at full rate.
    n0 = n_out;
    for (int i = 0; i < 1000; i++) begin
      a = rnd_below(Q1);
      b = rnd_below(Q1);
      drive(a, b, Q1, mu1, 8'(i), mod_ref(a, b, Q1));
    end
    drain(20);
    chk("stream_count", 64'(n_out - n0), 64'd1000);

    // Modulus changes every transaction.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        a = rnd_below(Q1);
        b = rnd_below(Q1);
        drive(a, b, Q1, mu1, 8'(8'h40 + i), mod_ref(a, b, Q1));
      end else begin
        a = rnd_below(Q2);
        b = rnd_below(Q2);
        drive(a, b, Q2, mu2, 8'(8'h40 + i), mod_ref(a, b, Q2));
      end
    end
    drive(Q2 - 64'd1, Q2 - 64'd1, Q2, mu2, 8'h5F, 64'd1);
    drain(20);

    // Eight inputs with the sink stalled for five cycles mid-stream.
    for (int i = 0; i < 8; i++) begin
      sa[i]  = rnd_below(Q1);
      sbv[i] = rnd_below(Q1);
    end
    chk_lat    = 1'b0;
    n_stall    = 0;
    n_notready = 0;
    n0         = n_out;
    k          = 0;
    for (int i = 0; i < 40 && (k < 8 || sb.size() > 0); i++) begin
      out_ready = !(i >= 5 && i < 10);
      if (k < 8) begin
        in_valid = 1'b1;
        in_a     = sa[k];
        in_b     = sbv[k];
        in_q     = Q1;
        in_mu    = mu1;
        in_tag   = 8'(8'h80 + k);
        cur_exp  = mod_ref(sa[k], sbv[k], Q1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (xfer_in) k++;
    end
    out_ready = 1'b1;
    chk("stall_cycles", 64'(n_stall), 64'd5);
    chk("notready_cycles", 64'(n_notready), 64'd5);
    chk("stall_accepted", 64'(k), 64'd8);
    chk("stall_outputs", 64'(n_out - n0), 64'd8);
    drain(10);
    chk_lat = 1'b1;

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      a = rnd_below(Q1);
      b = rnd_below(Q1);
      drive(a, b, Q1, mu1, 8'(8'hA0 + i), mod_ref(a, b, Q1));
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    n0 = n_out;
    repeat (8) idle();
    chk("no_stale", 64'(n_out - n0), 64'd0);
    drive(64'd7, 64'd9, Q1, mu1, 8'hC3, 64'd63);
    drain(10);
    chk("post_rst_count", 64'(n_out - n0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
